// File: rtl/mac_seq_driver.sv
// mac_seq_driver: sequences one MAC job (cfg, enable, operand burst, drain, read) and returns the result.
// Latency: mac_cfg 1 cycle after start, first mac_valid at +3, res_valid at +N+5 when operands keep pace.
// Backpressure: op_ready drops on a full FIFO or once len operands are taken; res_data/res_error hold until res_ready.
// Optional feature: define MAC_SEQ_TIMEOUT_EN to abort a job after TIMEOUT consecutive starved STREAM cycles.
module mac_seq_driver #(
    parameter int DATA_W     = 16,
    parameter int LEN_W      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              start_mode,
    input  logic [LEN_W-1:0]  start_len,
    output logic              busy,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              mac_enable,
    output logic              mac_valid,
    output logic              mac_read,
    output logic              mac_cfg,
    output logic              mac_mode,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    input  logic [DATA_W-1:0] mac_out,
    input  logic              mac_error,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_error
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_ENA,
        S_STREAM,
        S_DRAIN,
        S_READ,
        S_RESULT
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              mode_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  push_cnt;
    logic [LEN_W-1:0]  pop_cnt;
    logic [DATA_W-1:0] fifo_a [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_b [FIFO_DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic              accept;
    logic              to_hit;
    logic              op_window;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign busy      = (state != S_IDLE);
    assign op_window = (state == S_CFG) || (state == S_ENA) || (state == S_STREAM);
    assign op_ready  = op_window && !fifo_full && (push_cnt < len_q);
    assign push      = op_valid && op_ready;
    assign pop       = (state == S_STREAM) && !fifo_empty;

    // Operands reach the MAC only from the FIFO head, so no op-to-mac combinational path exists.
    assign mac_valid = pop;
    assign mac_a     = pop ? fifo_a[rd_ptr[AW-1:0]] : '0;
    assign mac_b     = pop ? fifo_b[rd_ptr[AW-1:0]] : '0;
    assign mac_mode  = mode_q;

`ifdef MAC_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] starve_cnt;

    // The hit fires on the TIMEOUT-th consecutive empty STREAM cycle.
    assign to_hit = (state == S_STREAM) && fifo_empty && (starve_cnt == TO_W'(TIMEOUT - 1));

    // Count consecutive empty STREAM cycles; any pop or other state clears it.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            starve_cnt <= '0;
        end else if ((state == S_STREAM) && fifo_empty) begin
            starve_cnt <= starve_cnt + TO_W'(1);
        end else begin
            starve_cnt <= '0;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign to_hit         = 1'b0;
`endif

    // FIFO pointers; a timeout flush discards anything still queued.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (to_hit) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // FIFO storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a[wr_ptr[AW-1:0]] <= op_a;
            fifo_b[wr_ptr[AW-1:0]] <= op_b;
        end
    end

    // Job descriptor and per-job push/pop counters, restarted on each accepted job.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            mode_q   <= 1'b0;
            len_q    <= '0;
            push_cnt <= '0;
            pop_cnt  <= '0;
        end else if (accept) begin
            mode_q   <= start_mode;
            len_q    <= start_len;
            push_cnt <= '0;
            pop_cnt  <= '0;
        end else begin
            if (push) push_cnt <= push_cnt + LEN_W'(1);
            if (pop)  pop_cnt  <= pop_cnt + LEN_W'(1);
        end
    end

    // Capture the MAC result during READ, or a zero/error result on starvation abort.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            res_data  <= '0;
            res_error <= 1'b0;
        end else if (state == S_READ) begin
            res_data  <= mac_out;
            res_error <= mac_error;
        end else if (to_hit) begin
            res_data  <= '0;
            res_error <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and MAC control decode.
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        mac_cfg    = 1'b0;
        mac_enable = 1'b0;
        mac_read   = 1'b0;
        res_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && (start_len != '0)) begin
                    accept    = 1'b1;
                    state_nxt = S_CFG;
                end
            end
            S_CFG: begin
                mac_cfg   = 1'b1;
                state_nxt = S_ENA;
            end
            S_ENA: begin
                mac_enable = 1'b1;
                state_nxt  = S_STREAM;
            end
            S_STREAM: begin
                mac_enable = 1'b1;
                if (pop && (pop_cnt == len_q - LEN_W'(1))) begin
                    state_nxt = S_DRAIN;
                end else if (to_hit) begin
                    state_nxt = S_RESULT;
                end
            end
            S_DRAIN: begin
                mac_enable = 1'b1;
                state_nxt  = S_READ;
            end
            S_READ: begin
                mac_enable = 1'b1;
                mac_read   = 1'b1;
                state_nxt  = S_RESULT;
            end
            S_RESULT: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_mac_seq_driver.sv
// tb_mac_seq_driver: drives jobs into mac_seq_driver with a behavioural MAC attached and checks every cycle.
// Expected behaviour comes from a job-level model: operand queue, FIFO occupancy and phase offsets.
// Build with MAC_SEQ_TIMEOUT_EN defined to exercise the starvation abort; otherwise starvation just waits.
module tb_mac_seq_driver;
    localparam int DW    = 16;
    localparam int LW    = 8;
    localparam int DEPTH = 2;
    localparam int TO    = 8;
`ifdef MAC_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          start_mode = 1'b0;
    logic [LW-1:0] start_len = '0;
    logic          busy;
    logic          op_valid = 1'b0;
    logic          op_ready;
    logic [DW-1:0] op_a = '0;
    logic [DW-1:0] op_b = '0;
    logic          mac_enable, mac_valid, mac_read, mac_cfg, mac_mode;
    logic [DW-1:0] mac_a, mac_b, mac_out;
    logic          mac_error;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [DW-1:0] res_data;
    logic          res_error;
    logic          err_en = 1'b0;
    logic [DW-1:0] acc;
    logic [56:0]   outs;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mac_seq_driver #(
        .DATA_W(DW), .LEN_W(LW), .FIFO_DEPTH(DEPTH), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_mode(start_mode), .start_len(start_len),
        .busy(busy), .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .mac_enable(mac_enable), .mac_valid(mac_valid), .mac_read(mac_read), .mac_cfg(mac_cfg),
        .mac_mode(mac_mode), .mac_a(mac_a), .mac_b(mac_b), .mac_out(mac_out), .mac_error(mac_error),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_error(res_error)
    );

    // Behavioural MAC: cfg clears, each enabled valid beat accumulates a*b.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)                        acc <= '0;
        else if (mac_cfg)                 acc <= '0;
        else if (mac_enable && mac_valid) acc <= acc + mac_a * mac_b;
    end
    assign mac_out   = acc;
    assign mac_error = err_en & mac_read;
    assign outs = {busy, op_ready, mac_enable, mac_valid, mac_read, mac_cfg, mac_mode,
                   mac_a, mac_b, res_valid, res_data, res_error};

    typedef struct {
        logic          mode;
        int            len;
        int            gap;
        int            stall;
        logic          err;
        bit            fixed;
        bit            inject;
        logic [DW-1:0] exp_res;
        logic          exp_err;
    } job_t;

    task automatic chkb(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %b, expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkw(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Runs one job starting from "#1 after a posedge" in IDLE; returns at the same point in IDLE.
    task automatic run_job(input job_t j, input int id);
        logic [DW-1:0] qa[$];
        logic [DW-1:0] qb[$];
        logic [DW-1:0] a, b, sum, exp_data;
        int    k, pushed, pops, occ, starve, gapc, e, res_start;
        bit    over, timed_out, done, exp_stream, exp_valid, exp_ordy, exp_en, exp_rv, push_now;
        string tag;
        tag = $sformatf("job%0d", id);
        sum = '0;
        for (int i = 0; i < j.len; i++) begin
            a = j.fixed ? DW'(2 * i + 1) : DW'($urandom);
            b = j.fixed ? DW'(2 * i + 2) : DW'($urandom);
            qa.push_back(a);
            qb.push_back(b);
            sum = sum + a * b;
        end
        exp_data = j.fixed ? j.exp_res : sum;

        err_en = j.err; start = 1'b1; start_mode = j.mode; start_len = LW'(j.len);
        op_valid = 1'b0; res_ready = 1'b0;
        @(posedge clk); #1;
        k = 1; pushed = 0; pops = 0; occ = 0; starve = 0; gapc = 0; e = 0; res_start = 0;
        over = 1'b0; timed_out = 1'b0; done = 1'b0;
        while (!done && k < 600) begin
            start = j.inject && (k >= 3);
            if (j.inject) begin
                start_mode = ~j.mode;
                start_len  = 8'd9;
            end
            if (gapc > 0) begin
                op_valid = 1'b0;
                gapc--;
            end else if (pushed < j.len) begin
                op_valid = 1'b1; op_a = qa[pushed]; op_b = qb[pushed];
            end else begin
                op_valid = (j.gap == 0); op_a = 16'hdead; op_b = 16'hbeef;
            end
            res_ready = over && (k >= res_start + j.stall);
            @(negedge clk);
            exp_stream = (k >= 3) && !over;
            exp_valid  = exp_stream && (occ > 0);
            exp_ordy   = !over && (occ < DEPTH) && (pushed < j.len);
            exp_en     = (k >= 2) && (!over || (!timed_out && (k <= e + 2)));
            exp_rv     = over && (k >= res_start);
            chkb({tag, ".busy"}, busy, 1'b1);
            chkb({tag, ".mac_cfg"}, mac_cfg, k == 1);
            chkb({tag, ".mac_mode"}, mac_mode, j.mode);
            chkb({tag, ".mac_enable"}, mac_enable, exp_en);
            chkb({tag, ".mac_valid"}, mac_valid, exp_valid);
            chkw({tag, ".mac_a"}, 64'(mac_a), exp_valid ? 64'(qa[pops]) : 64'd0);
            chkw({tag, ".mac_b"}, 64'(mac_b), exp_valid ? 64'(qb[pops]) : 64'd0);
            chkb({tag, ".mac_read"}, mac_read, over && !timed_out && (k == e + 2));
            chkb({tag, ".op_ready"}, op_ready, exp_ordy);
            chkb({tag, ".res_valid"}, res_valid, exp_rv);
            if (exp_rv) begin
                chkw({tag, ".res_data"}, 64'(res_data), timed_out ? 64'd0 : 64'(exp_data));
                chkb({tag, ".res_error"}, res_error, timed_out ? 1'b1 : j.exp_err);
            end
            push_now = op_valid && exp_ordy;
            if (exp_valid) begin
                pops++; occ--; starve = 0;
            end else if (exp_stream) begin
                starve++;
            end
            if (push_now) begin
                pushed++; occ++; gapc = j.gap;
            end
            if (exp_valid && (pops == j.len)) begin
                over = 1'b1; e = k; res_start = k + 3;
            end else if (TO_EN && exp_stream && !exp_valid && (starve == TO)) begin
                over = 1'b1; timed_out = 1'b1; e = k; res_start = k + 1; occ = 0;
            end
            if (exp_rv && res_ready) done = 1'b1;
            @(posedge clk); #1;
            k++;
        end
        chkb({tag, ".completed"}, done, 1'b1);
        start = 1'b0; op_valid = 1'b0; res_ready = 1'b0; err_en = 1'b0;
        @(negedge clk);
        chkb({tag, ".idle_busy"}, busy, 1'b0);
        chkb({tag, ".idle_cfg"}, mac_cfg, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        job_t tbl[7];
        job_t jr;
        tbl[0] = '{1'b0, 3,   0,  0, 1'b0, 1'b1, 1'b0, 16'h002C, 1'b0};
        tbl[1] = '{1'b1, 4,   2,  5, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0};
        tbl[2] = '{1'b0, 5,   0,  1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
        tbl[3] = '{1'b1, 2,   0,  0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1};
        tbl[4] = '{1'b0, 1,   0,  2, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
        tbl[5] = '{1'b1, 255, 0,  0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
        tbl[6] = '{1'b0, 4,   12, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};

        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chkw("reset.outputs", 64'(outs), 64'd0);
        chkb("reset.busy", busy, 1'b0);
        chkb("reset.res_valid", res_valid, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;

        // Zero-length start is ignored.
        start = 1'b1; start_mode = 1'b1; start_len = '0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chkb("len0.busy", busy, 1'b0);
        chkb("len0.mac_cfg", mac_cfg, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chkb("len0.mac_cfg_later", mac_cfg, 1'b0);
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) run_job(tbl[i], i);

        for (int i = 0; i < 8; i++) begin
            jr.mode    = logic'($urandom_range(0, 1));
            jr.len     = $urandom_range(1, 12);
            jr.gap     = $urandom_range(0, 3);
            jr.stall   = $urandom_range(0, 3);
            jr.err     = logic'($urandom_range(0, 1));
            jr.fixed   = 1'b0;
            jr.inject  = 1'b0;
            jr.exp_res = '0;
            jr.exp_err = jr.err;
            run_job(jr, 10 + i);
        end

        // Reset in the middle of STREAM with two operands still queued.
        start = 1'b1; start_mode = 1'b1; start_len = 8'd4;
        @(posedge clk); #1;
        start = 1'b0; op_valid = 1'b1; op_a = 16'd7; op_b = 16'd7;
        @(posedge clk); #1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        chkb("rst_mid.busy_before", busy, 1'b1);
        chkb("rst_mid.valid_before", mac_valid, 1'b1);
        #1 rst_n = 1'b1;
        #1 chkw("rst_mid.outputs_async", 64'(outs), 64'd0);
        @(negedge clk);
        chkw("rst_mid.outputs_next", 64'(outs), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        jr = '{1'b0, 1, 0, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
        run_job(jr, 30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached with %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end
endmodule
